// File: rtl/edulent_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edulent_pkg
// Purpose  : Shared EDULENT types: transfer commands, opcodes, target select.
// Revision : 1.0
// ============================================================================
package edulent_pkg;

    typedef enum logic [3:0] {
        CMD_NOP    = 4'h0,
        CMD_MA_PC  = 4'h1,
        CMD_MD_MEM = 4'h2,
        CMD_IR_MD  = 4'h3,
        CMD_MA_MD  = 4'h4,
        CMD_TGT_MD = 4'h5,
        CMD_MA_AP  = 4'h6,
        CMD_MA_SP  = 4'h7,
        CMD_MD_TGT = 4'h8,
        CMD_MEM_WR = 4'h9,
        CMD_RES    = 4'hA,
        CMD_PC_MD  = 4'hB,
        CMD_A_IN   = 4'hC,
        CMD_OUT_A  = 4'hD,
        CMD_PC_AP  = 4'hE,
        CMD_MD_PC  = 4'hF
    } transfer_cmd_t;

    localparam logic [1:0] C_SP_INC = 2'b01;
    localparam logic [1:0] C_SP_DEC = 2'b10;

    localparam logic [7:0] OP_HALT  = 8'h02;
    localparam logic [7:0] OP_AP_13 = 8'h13;
    localparam logic [7:0] OP_AP_1B = 8'h1B;
    localparam logic [7:0] OP_AP_1E = 8'h1E;
    localparam logic [7:0] OP_AP_23 = 8'h23;
    localparam logic [7:0] OP_AP_2E = 8'h2E;
    localparam logic [7:0] OP_AP_C1 = 8'hC1;

    // Opcodes whose operand moves go to AP rather than the accumulator
    function automatic logic is_ap_target(input logic [7:0] opcode);
        return (opcode == OP_AP_13) || (opcode == OP_AP_1B) ||
               (opcode == OP_AP_1E) || (opcode == OP_AP_23) ||
               (opcode == OP_AP_2E) || (opcode == OP_AP_C1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_transfer_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : register_transfer_unit_if
// Purpose  : Control, memory and ALU bus between control_unit and the RTU.
// Revision : 1.0
// ============================================================================
interface register_transfer_unit_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        i_transfer_cmd;
    logic              i_inc_pc;
    logic [1:0]        i_inc_dec_sp;
    logic              i_alu_calculate;
    logic              i_alu_res_to_ap;
    logic              i_reset_ir;
    logic [DATA_W-1:0] i_alu_result;
    logic [DATA_W-1:0] i_mem_rdata;
    logic [DATA_W-1:0] i_in_data;
    logic [7:0]        o_opcode;
    logic [DATA_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              o_mem_we;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [DATA_W-1:0] o_ap;
    logic [DATA_W-1:0] o_out_data;
    logic              o_out_valid;
    logic              o_halt;

    modport master (
        output i_transfer_cmd, i_inc_pc, i_inc_dec_sp, i_alu_calculate,
               i_alu_res_to_ap, i_reset_ir, i_alu_result, i_mem_rdata, i_in_data,
        input  o_opcode, o_mem_addr, o_mem_wdata, o_mem_we, o_alu_a, o_alu_b,
               o_ap, o_out_data, o_out_valid, o_halt
    );

    modport slave (
        input  i_transfer_cmd, i_inc_pc, i_inc_dec_sp, i_alu_calculate,
               i_alu_res_to_ap, i_reset_ir, i_alu_result, i_mem_rdata, i_in_data,
        output o_opcode, o_mem_addr, o_mem_wdata, o_mem_we, o_alu_a, o_alu_b,
               o_ap, o_out_data, o_out_valid, o_halt
    );
endinterface
`default_nettype wire

// File: rtl/register_transfer_unit_sp_counter.sv
`default_nettype none
// ============================================================================
// Module   : sp_counter
// Purpose  : Wrapping up/down stack pointer with synchronous reset.
// Revision : 1.0
// ============================================================================
module sp_counter
    import edulent_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] SP_INIT = '0
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    input  wire logic [1:0]        i_inc_dec,
    output logic      [DATA_W-1:0] o_sp
);
    logic [DATA_W-1:0] r_sp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp <= SP_INIT;
        end else begin
            case (i_inc_dec)
                C_SP_INC: r_sp <= r_sp + 1'b1;
                C_SP_DEC: r_sp <= r_sp - 1'b1;
                default:  r_sp <= r_sp;
            endcase
        end
    end

    assign o_sp = r_sp;
endmodule
`default_nettype wire

// File: rtl/register_transfer_unit.sv
`default_nettype none
// ============================================================================
// Module   : register_transfer_unit
// Purpose  : EDULENT register file and one-command-per-cycle transfer engine.
// Revision : 1.0
// ============================================================================
module register_transfer_unit
    import edulent_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter logic [DATA_W-1:0] SP_INIT  = '0
) (
    input  wire logic                i_clk,
    input  wire logic                i_rst,
    register_transfer_unit_if.slave  bus
);
    transfer_cmd_t     w_cmd;
    logic              w_ap_tgt;
    logic [DATA_W-1:0] w_sp;

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ma;
    logic [DATA_W-1:0] r_md;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_ap;
    logic [DATA_W-1:0] r_r;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;

    assign w_cmd    = transfer_cmd_t'(bus.i_transfer_cmd);
    assign w_ap_tgt = is_ap_target(r_ir[7:0]);

    sp_counter #(
        .DATA_W  (DATA_W),
        .SP_INIT (SP_INIT)
    ) u_sp_counter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_inc_dec (bus.i_inc_dec_sp),
        .o_sp      (w_sp)
    );

    // Default updates come first so a command in the case below overrides
    // the PC increment and the IR clear in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc        <= PC_RESET;
            r_ma        <= '0;
            r_md        <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_ap        <= '0;
            r_r         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.i_alu_calculate) r_r  <= bus.i_alu_result;
            if (bus.i_reset_ir)      r_ir <= '0;
            if (bus.i_inc_pc)        r_pc <= r_pc + 1'b1;

            case (w_cmd)
                CMD_MA_PC:  r_ma <= r_pc;
                CMD_MD_MEM: r_md <= bus.i_mem_rdata;
                CMD_IR_MD:  r_ir <= r_md;
                CMD_MA_MD:  r_ma <= r_md;
                CMD_TGT_MD: begin
                    if (w_ap_tgt) r_ap <= r_md;
                    else          r_a  <= r_md;
                end
                CMD_MA_AP:  r_ma <= r_ap;
                CMD_MA_SP:  r_ma <= w_sp;
                CMD_MD_TGT: r_md <= w_ap_tgt ? r_ap : r_a;
                CMD_RES: begin
                    if (bus.i_alu_res_to_ap) r_ap <= r_r;
                    else                     r_a  <= r_r;
                end
                CMD_PC_MD:  r_pc <= r_md;
                CMD_A_IN:   r_a  <= bus.i_in_data;
                CMD_OUT_A: begin
                    r_out       <= r_a;
                    r_out_valid <= 1'b1;
                end
                CMD_PC_AP:  r_pc <= r_ap;
                CMD_MD_PC:  r_md <= r_pc;
                default: ;
            endcase
        end
    end

    // control_unit decodes in the IR-load cycle, so forward MD then
    assign bus.o_opcode    = (w_cmd == CMD_IR_MD) ? r_md[7:0] : r_ir[7:0];
    assign bus.o_mem_addr  = r_ma;
    assign bus.o_mem_wdata = r_md;
    assign bus.o_mem_we    = (w_cmd == CMD_MEM_WR);
    assign bus.o_alu_a     = r_a;
    assign bus.o_alu_b     = r_md;
    assign bus.o_ap        = r_ap;
    assign bus.o_out_data  = r_out;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_halt      = (r_ir[7:0] == OP_HALT);
endmodule
`default_nettype wire
